// File: rtl/circle_raster_scan_if.sv
// Bus bundle for circle_raster_scan: Avalon-MM read master plus the packed pixel stream.
// Latency: none (wires only).
// Backpressure: m_waitrequest stalls the read request; out_ready stalls the word stream.
//
// Ports: master modport = scanner side (drives m_address/m_read/out_*),
//        slave modport  = pixel-query slave and stream consumer side.
interface circle_raster_scan_if #(
    parameter int XW = 9,
    parameter int YW = 9
);
    logic [XW+YW-1:0] m_address;
    logic             m_read;
    logic             m_waitrequest;
    logic [31:0]      m_readdata;
    logic             m_readdatavalid;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_eol;
    logic             out_last;

    modport master (
        output m_address, m_read,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        output out_data, out_valid, out_eol, out_last,
        input  out_ready
    );

    modport slave (
        input  m_address, m_read,
        output m_waitrequest, m_readdata, m_readdatavalid,
        input  out_data, out_valid, out_eol, out_last,
        output out_ready
    );
endinterface

// File: rtl/circle_raster_scan.sv
// Window scanner: one pixel-query read per {y,x}, OR-reduced to a bit, packed 32 px/word in row order.
// Latency: first read the cycle after start; a word is valid the cycle after its last pixel is captured.
// Backpressure: one completed word may wait in the pack register; reads stop until the output register drains.
//
// Ports: clk, reset_n (async, active low); start + win_x0/win_y0/win_w/win_h window capture;
//        busy/done status; bus.master carries the Avalon read master and the out_* word stream.
module circle_raster_scan #(
    parameter int XW = 9,
    parameter int YW = 9
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [XW-1:0] win_x0,
    input  logic [YW-1:0] win_y0,
    input  logic [XW:0]   win_w,
    input  logic [YW:0]   win_h,
    output logic          busy,
    output logic          done,
    circle_raster_scan_if.master bus
);

    typedef enum logic [2:0] {IDLE, REQ, RESP, FLUSH, DONE} state_t;

    state_t        state, state_nxt;

    // Captured window
    logic [XW-1:0] cap_x0;
    logic [XW:0]   cap_w;
    logic [YW:0]   cap_h;

    // Scan position
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW:0]   col_cnt;
    logic [YW:0]   row_cnt;

    // Pack register; also holds a finished word while the output register is occupied
    logic [31:0]   pack;
    logic          pend;
    logic          pend_eol;
    logic          pend_last;

    // Output register
    logic [31:0]   out_data_q;
    logic          out_valid_q;
    logic          out_eol_q;
    logic          out_last_q;

    // Datapath decode
    logic          cap;
    logic          pix;
    logic [31:0]   word_bits;
    logic [XW:0]   col_next;
    logic          row_end;
    logic          word_done;
    logic          frame_end;
    logic          out_free;
    logic          xfer_last;
    logic          load_new;
    logic          store_pend;
    logic          load_pend;
    logic          win_empty;

    always_comb begin
        pix        = |bus.m_readdata;
        word_bits  = pack | (32'(pix) << col_cnt[4:0]);
        col_next   = col_cnt + 1'b1;
        row_end    = (col_next == cap_w);
        word_done  = row_end || (col_next[4:0] == 5'd0);
        frame_end  = row_end && (row_cnt == cap_h - 1'b1);
        // The output register can take a new word if it is empty or being transferred now
        out_free   = !out_valid_q || bus.out_ready;
        xfer_last  = out_valid_q && bus.out_ready && out_last_q;
        win_empty  = (win_w == '0) || (win_h == '0);
    end

    // Next-state and capture decode
    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = win_empty ? DONE : REQ;
            end
            REQ: begin
                if (!bus.m_waitrequest) begin
                    if (bus.m_readdatavalid) cap = 1'b1;
                    else                     state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.m_readdatavalid) cap = 1'b1;
            end
            FLUSH: begin
                if (pend) begin
                    // A final word still has to be accepted before DONE, so stay here after loading it
                    if (out_free && !pend_last) state_nxt = REQ;
                end else if (xfer_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (cap) begin
            if (word_done && (frame_end || !out_free)) state_nxt = FLUSH;
            else                                       state_nxt = REQ;
        end
    end

    assign load_new   = cap && word_done && out_free;
    assign store_pend = cap && word_done && !out_free;
    assign load_pend  = (state == FLUSH) && pend && out_free;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_x0      <= '0;
            cap_w       <= '0;
            cap_h       <= '0;
            x           <= '0;
            y           <= '0;
            col_cnt     <= '0;
            row_cnt     <= '0;
            pack        <= '0;
            pend        <= 1'b0;
            pend_eol    <= 1'b0;
            pend_last   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                cap_x0  <= win_x0;
                cap_w   <= win_w;
                cap_h   <= win_h;
                x       <= win_x0;
                y       <= win_y0;
                col_cnt <= '0;
                row_cnt <= '0;
                pack    <= '0;
                pend    <= 1'b0;
            end

            if (cap) begin
                if (row_end) begin
                    x       <= cap_x0;
                    y       <= y + 1'b1;
                    col_cnt <= '0;
                    row_cnt <= row_cnt + 1'b1;
                end else begin
                    x       <= x + 1'b1;
                    col_cnt <= col_next;
                end

                if (store_pend) begin
                    pack      <= word_bits;
                    pend      <= 1'b1;
                    pend_eol  <= row_end;
                    pend_last <= frame_end;
                end else if (load_new) begin
                    pack <= '0;
                end else begin
                    pack <= word_bits;
                end
            end

            if (load_new) begin
                out_data_q  <= word_bits;
                out_eol_q   <= row_end;
                out_last_q  <= frame_end;
                out_valid_q <= 1'b1;
            end else if (load_pend) begin
                out_data_q  <= pack;
                out_eol_q   <= pend_eol;
                out_last_q  <= pend_last;
                out_valid_q <= 1'b1;
                pend        <= 1'b0;
                pack        <= '0;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign busy          = (state == REQ) || (state == RESP) || (state == FLUSH);
    assign done          = (state == DONE);
    assign bus.m_read    = (state == REQ);
    assign bus.m_address = {y, x};
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_eol   = out_eol_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_circle_raster_scan.sv
module tb_circle_raster_scan;
    localparam int XW = 9;
    localparam int YW = 9;
    localparam int AW = XW + YW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [XW-1:0] win_x0 = '0;
    logic [YW-1:0] win_y0 = '0;
    logic [XW:0]   win_w = '0;
    logic [YW:0]   win_h = '0;
    logic          busy;
    logic          done;

    circle_raster_scan_if #(.XW(XW), .YW(YW)) bus ();

    circle_raster_scan #(.XW(XW), .YW(YW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .win_x0  (win_x0),
        .win_y0  (win_y0),
        .win_w   (win_w),
        .win_h   (win_h),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        eol;
        logic        last;
    } word_t;

    word_t         exp_words[$];
    logic [AW-1:0] exp_addr[$];

    int n_chk = 0;
    int n_pass = 0;
    int n_reads = 0;
    int n_words = 0;
    int n_done = 0;
    int cyc_now = 0;
    int last_xfer_cyc = 0;
    logic [31:0] last_data = '0;

    // Slave / consumer configuration
    int cfg_wait = 0;
    int cfg_lat = 0;
    int wait_left = 0;
    int lat_left = 0;
    logic pend = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    int bp_len = 0;
    int bp_left = 0;
    logic bp_arm = 1'b0;
    int bp_reads = 0;
    logic hold_vld = 1'b0;
    logic [31:0] hold_data = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference pixel query: ring of radius 5 around (100,100)
    function automatic logic on_circle(input int x, input int y);
        int d;
        d = (x - 100) * (x - 100) + (y - 100) * (y - 100) - 25;
        return (d > -5) && (d <= 5);
    endfunction

    function automatic logic [31:0] pix_data(input logic [AW-1:0] a);
        int px;
        int py;
        px = int'(a[XW-1:0]);
        py = int'(a[AW-1:XW]);
        if (on_circle(px, py)) return 32'h1 << $urandom_range(31, 0);
        return 32'h0;
    endfunction

    // Slave, consumer and scoreboard, all evaluated just after each rising edge
    initial begin
        bus.m_waitrequest   = 1'b0;
        bus.m_readdatavalid = 1'b0;
        bus.m_readdata      = '0;
        bus.out_ready       = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc_now++;
            if (done) n_done++;

            bus.out_ready = (bp_left == 0);
            if (bp_left > 0) bp_left--;

            if (reset_n) begin
                if (hold_vld) begin
                    check("stall_valid", bus.out_valid, 1'b1);
                    check("stall_data", bus.out_data, hold_data);
                end
                hold_vld  = bus.out_valid && !bus.out_ready;
                hold_data = bus.out_data;
                if (bus.out_valid && bus.out_ready) begin
                    n_words++;
                    last_data = bus.out_data;
                    if (bus.out_last) last_xfer_cyc = cyc_now;
                    if (exp_words.size() == 0) begin
                        check("word_unexpected", 1, 0);
                    end else begin
                        word_t w;
                        w = exp_words.pop_front();
                        check("word_data", bus.out_data, w.data);
                        check("word_eol", bus.out_eol, w.eol);
                        check("word_last", bus.out_last, w.last);
                    end
                    if (bp_arm) begin
                        bp_left = bp_len;
                        bp_arm  = 1'b0;
                    end
                end
            end else begin
                hold_vld = 1'b0;
            end

            bus.m_readdatavalid = 1'b0;
            bus.m_waitrequest   = 1'b0;
            if (pend) begin
                if (lat_left == 0) begin
                    bus.m_readdatavalid = 1'b1;
                    bus.m_readdata      = pix_data(pend_addr);
                    pend = 1'b0;
                end else begin
                    lat_left--;
                end
            end
            if (bus.m_read) begin
                if (pend) check("one_outstanding", 1, 0);
                if (!bus.out_ready) bp_reads++;
                if (exp_addr.size() == 0) begin
                    check("read_unexpected", 1, 0);
                end else if (wait_left > 0) begin
                    bus.m_waitrequest = 1'b1;
                    wait_left--;
                    check("addr_stable", bus.m_address, exp_addr[0]);
                end else begin
                    logic [AW-1:0] a;
                    a = exp_addr.pop_front();
                    n_reads++;
                    check("addr", bus.m_address, a);
                    wait_left = cfg_wait;
                    if (cfg_lat == 0) begin
                        bus.m_readdatavalid = 1'b1;
                        bus.m_readdata      = pix_data(bus.m_address);
                    end else begin
                        pend      = 1'b1;
                        pend_addr = bus.m_address;
                        lat_left  = cfg_lat - 1;
                    end
                end
            end
        end
    end

    task automatic set_slave(input int wt, input int lat);
        cfg_wait  = wt;
        cfg_lat   = lat;
        wait_left = wt;
    endtask

    task automatic run_scan(input int x0, input int y0, input int w, input int h);
        int reads0;
        int words0;
        int done0;
        int nexp;
        int cyc;
        logic [31:0] acc;
        int px;
        int py;
        reads0 = n_reads;
        words0 = n_words;
        done0  = n_done;
        nexp   = 0;
        for (int r = 0; r < h; r++) begin
            acc = '0;
            for (int c = 0; c < w; c++) begin
                logic [XW-1:0] xa;
                logic [YW-1:0] ya;
                px = (x0 + c) % (1 << XW);
                py = (y0 + r) % (1 << YW);
                xa = px[XW-1:0];
                ya = py[YW-1:0];
                exp_addr.push_back({ya, xa});
                acc[c % 32] = on_circle(px, py);
                if ((c % 32 == 31) || (c == w - 1)) begin
                    exp_words.push_back({acc, c == w - 1, (c == w - 1) && (r == h - 1)});
                    nexp++;
                    acc = '0;
                end
            end
        end
        @(posedge clk);
        #2;
        win_x0 = x0[XW-1:0];
        win_y0 = y0[YW-1:0];
        win_w  = w[XW:0];
        win_h  = h[YW:0];
        start  = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        check("busy_cycle1", busy, (w != 0) && (h != 0));
        check("mread_cycle1", bus.m_read, (w != 0) && (h != 0));
        cyc = 0;
        while ((n_done == done0) && (cyc < 20000)) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check("done_seen", n_done - done0, 1);
        check("done_busy_low", busy, 1'b0);
        if (nexp > 0) check("done_after_last", cyc_now - last_xfer_cyc, 1);
        check("reads", n_reads - reads0, w * h);
        check("words", n_words - words0, nexp);
        check("addr_q_empty", exp_addr.size(), 0);
        check("word_q_empty", exp_words.size(), 0);
        @(posedge clk);
        #2;
        check("done_pulse", done, 1'b0);
    endtask

    initial begin
        int cyc;
        // Reset state
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_mread", bus.m_read, 1'b0);
        check("rst_addr", bus.m_address, 0);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_data", bus.out_data, 0);
        check("rst_eol", bus.out_eol, 1'b0);
        check("rst_last", bus.out_last, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b1;

        // Single full row word
        set_slave(0, 0);
        run_scan(90, 100, 32, 1);
        check("row32_data", last_data, 32'h0000_8020);

        // Two words in one row
        run_scan(90, 100, 40, 1);
        check("row40_tail", last_data, 32'h0);

        // Horizontal wrap
        run_scan(500, 100, 20, 1);

        // Backpressure after the first word
        bp_reads = 0;
        bp_len   = 45;
        bp_arm   = 1'b1;
        run_scan(90, 97, 70, 2);
        check("bp_reads_halt", bp_reads < bp_len, 1'b1);

        // Slow slave over the whole ring, several rows
        set_slave(2, 3);
        run_scan(93, 93, 14, 15);

        // Degenerate windows
        run_scan(10, 10, 0, 5);
        run_scan(10, 10, 7, 0);

        // Reset during an outstanding read
        set_slave(0, 3);
        run_scan_abort: begin
            int x0;
            x0 = 0;
            for (int c = 0; c < 64; c++) begin
                logic [XW-1:0] xa;
                xa = c[XW-1:0];
                exp_addr.push_back({9'd0, xa});
            end
            @(posedge clk);
            #2;
            win_x0 = x0[XW-1:0];
            win_y0 = '0;
            win_w  = 10'd64;
            win_h  = 10'd1;
            start  = 1'b1;
            @(posedge clk);
            #2;
            start = 1'b0;
            repeat (6) @(posedge clk);
            cyc = 0;
            while (!pend && (cyc < 50)) begin
                @(posedge clk);
                #2;
                cyc++;
            end
            check("abort_pending", pend, 1'b1);
            #1;
            reset_n = 1'b0;
            #1;
            check("abort_busy", busy, 1'b0);
            check("abort_mread", bus.m_read, 1'b0);
            check("abort_addr", bus.m_address, 0);
            check("abort_valid", bus.out_valid, 1'b0);
            check("abort_data", bus.out_data, 0);
            @(posedge clk);
            #3;
            reset_n = 1'b1;
            exp_addr.delete();
            exp_words.delete();
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #2;
                check("post_rst_mread", bus.m_read, 1'b0);
                check("post_rst_busy", busy, 1'b0);
                check("post_rst_valid", bus.out_valid, 1'b0);
            end
            check("stale_resp_gone", pend, 1'b0);
        end

        // Clean scan after the abort
        set_slave(0, 0);
        run_scan(90, 100, 32, 1);
        check("after_rst_data", last_data, 32'h0000_8020);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
